// File: rtl/c17_bist_pkg.sv
// Shared types, constants and the golden c17 model for the c17 BIST controller.
package c17_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } bist_state_t;

    localparam int NPAT_EXH  = 32;
    localparam int NPAT_LFSR = 31;

    // Fibonacci LFSR x^5+x^3+1: feedback is bit4 ^ bit2, shifted in at bit0.
    localparam logic [4:0] LFSR_TAPS = 5'b10100;
    localparam logic [4:0] LFSR_SEED = 5'h01;

    // Bit positions of the c17 primary inputs inside cut_in = {N1,N2,N3,N6,N7}.
    localparam int BIT_N1 = 4;
    localparam int BIT_N2 = 3;
    localparam int BIT_N3 = 2;
    localparam int BIT_N6 = 1;
    localparam int BIT_N7 = 0;

    function automatic logic [4:0] lfsr_next(input logic [4:0] cur);
        return {cur[3:0], ^(cur & LFSR_TAPS)};
    endfunction

    // Golden c17: returns {N22,N23}.
    function automatic logic [1:0] c17_golden(input logic [4:0] pat);
        logic n10;
        logic n11;
        logic n16;
        logic n19;
        n10 = ~(pat[BIT_N1] & pat[BIT_N3]);
        n11 = ~(pat[BIT_N3] & pat[BIT_N6]);
        n16 = ~(pat[BIT_N2] & n11);
        n19 = ~(n11 & pat[BIT_N7]);
        return {~(n10 & n16), ~(n16 & n19)};
    endfunction

endpackage

// File: rtl/c17_misr.sv
// Multiple-input signature register compacting the 2-bit c17 response stream.
module c17_misr
    import c17_bist_pkg::*;
#(
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021,
    parameter logic [MISR_W-1:0] MISR_SEED = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    input  logic [1:0]        din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_r;
    logic [MISR_W-1:0] sig_nx_s;

    // Next signature: shift left, fold in the polynomial on carry-out, xor the response.
    always_comb begin
        sig_nx_s = {sig_r[MISR_W-2:0], 1'b0}
                 ^ (sig_r[MISR_W-1] ? MISR_POLY : {MISR_W{1'b0}})
                 ^ {{(MISR_W-2){1'b0}}, din};
    end

    // Signature register: seed on load, compact on enable, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_r <= MISR_SEED;
        end else if (load) begin
            sig_r <= MISR_SEED;
        end else if (en) begin
            sig_r <= sig_nx_s;
        end else begin
            sig_r <= sig_r;
        end
    end

    assign sig = sig_r;

endmodule

// File: rtl/c17_bist_ctrl.sv
// c17 BIST controller: pattern generation, golden compare, error tracking and MISR.
module c17_bist_ctrl
    import c17_bist_pkg::*;
#(
    parameter int                SETTLE_CYC = 2,
    parameter int                MISR_W     = 16,
    parameter logic [MISR_W-1:0] MISR_POLY  = 16'h1021,
    parameter logic [MISR_W-1:0] MISR_SEED  = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    output logic [4:0]        cut_in,
    input  logic [1:0]        cut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [5:0]        err_cnt,
    output logic              first_fail_vld,
    output logic [4:0]        first_fail_idx,
    output logic [MISR_W-1:0] signature
);

    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    bist_state_t state_r;
    bist_state_t state_nx_s;
    logic           mode_r;
    logic [4:0]     idx_r;
    logic [4:0]     pat_r;
    logic [SCW-1:0] settle_r;
    logic [4:0]     cut_in_r;
    logic           busy_r;
    logic           done_r;
    logic           pass_r;
    logic [5:0]     err_cnt_r;
    logic           ff_vld_r;
    logic [4:0]     ff_idx_r;

    logic start_s;
    logic abort_s;
    logic capture_s;
    logic mismatch_s;
    logic last_pat_s;
    logic last_settle_s;

    assign start_s       = (state_r == ST_IDLE) && start;
    assign abort_s       = (state_r != ST_IDLE) && abort;
    assign capture_s     = (state_r == ST_CAPTURE) && !abort;
    assign mismatch_s    = capture_s && (cut_out != c17_golden(cut_in_r));
    assign last_pat_s    = mode_r ? (idx_r == 5'(NPAT_LFSR - 1)) : (idx_r == 5'(NPAT_EXH - 1));
    assign last_settle_s = (settle_r == SCW'(SETTLE_CYC - 1));

    // Next-state logic; abort overrides every non-idle state.
    always_comb begin
        state_nx_s = state_r;
        if (abort_s) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:    state_nx_s = start ? ST_APPLY : ST_IDLE;
                ST_APPLY:   state_nx_s = ST_SETTLE;
                ST_SETTLE:  state_nx_s = last_settle_s ? ST_CAPTURE : ST_SETTLE;
                ST_CAPTURE: state_nx_s = last_pat_s ? ST_DONE : ST_APPLY;
                ST_DONE:    state_nx_s = ST_IDLE;
                default:    state_nx_s = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Settle counter runs only while in SETTLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_r <= {SCW{1'b0}};
        end else if (state_r == ST_SETTLE) begin
            settle_r <= settle_r + SCW'(1);
        end else begin
            settle_r <= {SCW{1'b0}};
        end
    end

    // Run context: latched mode, pattern index and current pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r <= 1'b0;
            idx_r  <= 5'd0;
            pat_r  <= 5'd0;
        end else if (start_s) begin
            mode_r <= mode;
            idx_r  <= 5'd0;
            pat_r  <= mode ? LFSR_SEED : 5'd0;
        end else if (capture_s && !last_pat_s) begin
            idx_r  <= idx_r + 5'd1;
            pat_r  <= mode_r ? lfsr_next(pat_r) : (pat_r + 5'd1);
        end else begin
            idx_r  <= idx_r;
            pat_r  <= pat_r;
        end
    end

    // CUT drive: pattern loaded in APPLY, forced to zero whenever the run is not active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cut_in_r <= 5'd0;
        end else if ((state_nx_s == ST_IDLE) || (state_nx_s == ST_DONE)) begin
            cut_in_r <= 5'd0;
        end else if (state_r == ST_APPLY) begin
            cut_in_r <= pat_r;
        end else begin
            cut_in_r <= cut_in_r;
        end
    end

    // Error counter and first-fail capture; frozen outside CAPTURE and on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= 6'd0;
            ff_vld_r  <= 1'b0;
            ff_idx_r  <= 5'd0;
        end else if (start_s) begin
            err_cnt_r <= 6'd0;
            ff_vld_r  <= 1'b0;
            ff_idx_r  <= 5'd0;
        end else if (mismatch_s) begin
            err_cnt_r <= err_cnt_r + 6'd1;
            ff_vld_r  <= 1'b1;
            ff_idx_r  <= ff_vld_r ? ff_idx_r : idx_r;
        end else begin
            err_cnt_r <= err_cnt_r;
            ff_vld_r  <= ff_vld_r;
            ff_idx_r  <= ff_idx_r;
        end
    end

    // Status flags: busy tracks the active states, done/pass are issued out of DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
        end else begin
            busy_r <= (state_nx_s == ST_APPLY) || (state_nx_s == ST_SETTLE) ||
                      (state_nx_s == ST_CAPTURE);
            done_r <= (state_r == ST_DONE) && !abort_s;
            if (start_s) begin
                pass_r <= 1'b0;
            end else if ((state_r == ST_DONE) && !abort_s) begin
                pass_r <= (err_cnt_r == 6'd0);
            end else begin
                pass_r <= pass_r;
            end
        end
    end

    c17_misr #(
        .MISR_W    (MISR_W),
        .MISR_POLY (MISR_POLY),
        .MISR_SEED (MISR_SEED)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_s),
        .en    (capture_s),
        .din   (cut_out),
        .sig   (signature)
    );

    assign cut_in         = cut_in_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign err_cnt        = err_cnt_r;
    assign first_fail_vld = ff_vld_r;
    assign first_fail_idx = ff_idx_r;

endmodule
